projectile_scheduler: RTL and testbench
=======================================

Name: projectile_scheduler

Overview:
- Owns the pool of projectile slots shared by player and NPC.
- Edge-detects shoot requests and arbitrates between the two shooters.
- Enforces per-shooter frame-based cooldown and per-owner slot limits, allocates a slot and issues a one-cycle launch to the projectile datapath.
- Frees slots on contact or off-screen and keeps saturating hit counts for the stage controller.

Parameters:
- NUM_SLOTS, 4, number of projectile slots; must be >= 2*MAX_PER_OWNER.
- MAX_PER_OWNER, 2, max simultaneously active slots per shooter.
- COOLDOWN_FRAMES, 15, frames after a launch before that shooter may fire again (1..63).
- X_OFFSET, 10'd16, horizontal spawn offset from the shooter centre.
- X_MAX, 10'd639, rightmost legal spawn X.

Ports:
- Clk  in  1  50 MHz system clock.
- Reset_n  in  1  asynchronous active-low reset.
- frame_clk  in  1  VGA_VS; asynchronous to the block, synchronized internally.
- enable  in  1  high during battle stage (battle_l).
- p_shoot, n_shoot  in  1 each  level shoot buttons; rising edge = request.
- p_x, p_y, n_x, n_y  in  10 each  shooter centre coordinates.
- slot_hit  in  NUM_SLOTS  per-slot contact from hitbox.
- slot_offscreen  in  NUM_SLOTS  per-slot out-of-bounds from projectile.
- slot_launch  out  NUM_SLOTS  one-hot, one-cycle launch pulse.
- launch_x, launch_y  out  10 each  spawn position, valid with slot_launch.
- launch_dir  out  1  0 = rightward (player), 1 = leftward (NPC).
- slot_active  out  NUM_SLOTS  slot is in LAUNCH or ACTIVE.
- slot_owner  out  NUM_SLOTS  0 = player, 1 = NPC; meaningful only when the slot is active.
- p_ready, n_ready  out  1 each  shooter may fire now.
- p_hits, n_hits  out  4 each  saturating count of hits scored by that owner.

Behaviour:
- Reset (async, Reset_n=0): all slots FREE.
- Reset clears all outputs: slot_launch, launch_x, launch_y, launch_dir, slot_active, slot_owner, p_hits and n_hits go to 0.
- Reset also clears cooldowns, pendings, edge/sync flops and the round-robin pointer (player first).
- p_ready and n_ready are 0 during reset; after release they follow enable and the ready rule.
- Frame tick: frame_clk passes through a 2-FF synchronizer; tick = one Clk pulse on the synced rising edge. Latency is 3 Clk from the raw edge.
- Cooldown: one 6-bit counter per shooter.
  - Loaded with COOLDOWN_FRAMES in the cycle its launch issues.
  - Decrements by 1 per tick; stops at 0.
- Ready rule: x_ready = enable & cooldown==0 & active-owned-count < MAX_PER_OWNER & ~pending.
- Request:
  - A shoot edge is registered: shoot=1 at cycle N with shoot=0 at N-1.
  - If x_ready at N, pending is set at N+1; otherwise the edge is dropped, not queued.
- Arbitration, evaluated each cycle with pending:
  - One grant per cycle.
  - If both shooters are pending, grant the round-robin pointer owner; the pointer then toggles.
  - A single pending shooter is granted immediately without moving the pointer.
  - Grant takes the lowest-index FREE slot. The parameter constraint guarantees a free slot exists.
- Launch:
  - The grant is evaluated in cycle N+1; slot_launch[i], launch_x, launch_y and launch_dir are registered and valid in cycle N+2.
  - The granted pending bit is cleared.
  - The other shooter stays pending and is granted next cycle.
- Spawn X, computed with an 11-bit intermediate:
  - Player: min(p_x + X_OFFSET, X_MAX).
  - NPC: n_x - X_OFFSET, clamped to 0 if n_x < X_OFFSET.
- Spawn Y is the shooter's y, unchanged.
- Per-slot FSM:
  - FREE -> LAUNCH on grant.
  - LAUNCH -> ACTIVE after exactly one cycle (the slot_launch cycle).
  - ACTIVE -> FREE when slot_hit[i] | slot_offscreen[i].
  - slot_hit and slot_offscreen are ignored in FREE and LAUNCH.
- Scoring:
  - A hit in ACTIVE increments the owner's count, saturating at 15.
  - Hit and offscreen in the same cycle free the slot and still score.
  - Simultaneous hits on several slots of the same owner in one cycle add their popcount, saturating at 15.
- enable low (battle end or soft reset):
  - Next cycle, all slots go FREE and slot_launch is suppressed.
  - Pendings and cooldowns are cleared.
  - Hit counts hold until enable rises again; they clear on the first cycle with enable=1 after enable=0.
- A shoot held high across the enable rise does not fire; a new rising edge is required.

Test Plan:
- Reset_n=0 with random inputs -> all outputs 0; release with enable=1 -> p_ready=n_ready=1 after 1 cycle.
- p_shoot rises at N, p_x=100, p_y=355 -> slot_launch=4'b0001 at N+2, launch_x=116, launch_y=355, launch_dir=0; p_ready=0 until 15 ticks.
- p_shoot and n_shoot rise in the same cycle, n_x=10 -> player launches slot0 at N+2, NPC slot1 at N+3 with launch_x=0; repeat after cooldown -> NPC is granted first.
- Player fires twice (cooldown elapsed), third edge while both slots active -> no launch, p_ready=0; slot_offscreen on one -> slot FREE, p_ready=1 next cycle.
- slot_hit and slot_offscreen on the same ACTIVE player slot -> slot freed, p_hits 0->1; 16 further hits -> p_hits=15.
- enable dropped while 3 slots are active -> slot_active=0 next cycle, cooldowns cleared; enable high again -> hits=0, shoot held high does not fire.

Source files
------------

// File: rtl/projectile_scheduler.sv
// Projectile slot pool: edge-detected shoot requests, round-robin arbitration,
// per-shooter frame cooldown, per-owner slot limits and saturating hit counters.
module projectile_scheduler #(
    parameter int         NUM_SLOTS       = 4,
    parameter int         MAX_PER_OWNER   = 2,
    parameter int         COOLDOWN_FRAMES = 15,
    parameter logic [9:0] X_OFFSET        = 10'd16,
    parameter logic [9:0] X_MAX           = 10'd639
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_clk,
    input  logic                 enable,
    input  logic                 p_shoot,
    input  logic                 n_shoot,
    input  logic [9:0]           p_x,
    input  logic [9:0]           p_y,
    input  logic [9:0]           n_x,
    input  logic [9:0]           n_y,
    input  logic [NUM_SLOTS-1:0] slot_hit,
    input  logic [NUM_SLOTS-1:0] slot_offscreen,
    output logic [NUM_SLOTS-1:0] slot_launch,
    output logic [9:0]           launch_x,
    output logic [9:0]           launch_y,
    output logic                 launch_dir,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic [NUM_SLOTS-1:0] slot_owner,
    output logic                 p_ready,
    output logic                 n_ready,
    output logic [3:0]           p_hits,
    output logic [3:0]           n_hits
);
    localparam int               CNT_W   = $clog2(NUM_SLOTS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PER_OWNER);
    localparam logic [5:0]       CD_LOAD = 6'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {S_FREE, S_LAUNCH, S_ACTIVE} slot_state_t;
    slot_state_t state      [NUM_SLOTS];
    slot_state_t state_next [NUM_SLOTS];

    logic             fs_meta, fs_sync, fs_prev, tick;
    logic             run, en_prev;
    logic             p_shoot_prev, n_shoot_prev;
    logic             p_pend, n_pend, rr;
    logic [5:0]       p_cd, n_cd;
    logic [CNT_W-1:0] p_cnt, n_cnt, p_hit_cnt, n_hit_cnt;
    logic             grant_any, grant_owner, slot_found, do_grant;
    logic [NUM_SLOTS-1:0] grant_vec;
    logic [10:0]      p_sum;
    logic [9:0]       spawn_x, spawn_y;
    logic [7:0]       p_hits_sum, n_hits_sum;

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_active
        assign slot_active[gi] = (state[gi] != S_FREE);
    end

    // Occupancy per owner (LAUNCH counts as occupied) and this cycle's scoring hits.
    always_comb begin
        p_cnt     = '0;
        n_cnt     = '0;
        p_hit_cnt = '0;
        n_hit_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (state[i] != S_FREE) begin
                if (slot_owner[i]) n_cnt = n_cnt + CNT_W'(1);
                else               p_cnt = p_cnt + CNT_W'(1);
            end
            if (state[i] == S_ACTIVE && slot_hit[i]) begin
                if (slot_owner[i]) n_hit_cnt = n_hit_cnt + CNT_W'(1);
                else               p_hit_cnt = p_hit_cnt + CNT_W'(1);
            end
        end
    end

    assign p_ready = run & enable & (p_cd == 6'd0) & (p_cnt < MAX_CNT) & ~p_pend;
    assign n_ready = run & enable & (n_cd == 6'd0) & (n_cnt < MAX_CNT) & ~n_pend;

    always_comb begin
        grant_any   = enable & (p_pend | n_pend);
        grant_owner = 1'b0;
        if (p_pend & n_pend) grant_owner = rr;
        else if (n_pend)     grant_owner = 1'b1;
        grant_vec  = '0;
        slot_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_found && state[i] == S_FREE) begin
                grant_vec[i] = 1'b1;
                slot_found   = 1'b1;
            end
        end
    end

    assign do_grant = grant_any & slot_found;

    // 11-bit sum so the player clamp sees overflow past 1023 as well.
    assign p_sum = {1'b0, p_x} + {1'b0, X_OFFSET};

    always_comb begin
        if (grant_owner) begin
            spawn_x = (n_x < X_OFFSET) ? 10'd0 : n_x - X_OFFSET;
            spawn_y = n_y;
        end else begin
            spawn_x = (p_sum > {1'b0, X_MAX}) ? X_MAX : p_sum[9:0];
            spawn_y = p_y;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            state_next[i] = state[i];
            if (!enable) begin
                state_next[i] = S_FREE;
            end else begin
                case (state[i])
                    S_FREE:   if (do_grant && grant_vec[i]) state_next[i] = S_LAUNCH;
                    S_LAUNCH: state_next[i] = S_ACTIVE;
                    S_ACTIVE: if (slot_hit[i] || slot_offscreen[i]) state_next[i] = S_FREE;
                    default:  state_next[i] = S_FREE;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) state[i] <= S_FREE;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) state[i] <= state_next[i];
        end
    end

    assign p_hits_sum = 8'(p_hits) + 8'(p_hit_cnt);
    assign n_hits_sum = 8'(n_hits) + 8'(n_hit_cnt);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fs_meta      <= 1'b0;
            fs_sync      <= 1'b0;
            fs_prev      <= 1'b0;
            tick         <= 1'b0;
            run          <= 1'b0;
            en_prev      <= 1'b0;
            p_shoot_prev <= 1'b0;
            n_shoot_prev <= 1'b0;
            p_pend       <= 1'b0;
            n_pend       <= 1'b0;
            rr           <= 1'b0;
            p_cd         <= 6'd0;
            n_cd         <= 6'd0;
            slot_launch  <= '0;
            launch_x     <= 10'd0;
            launch_y     <= 10'd0;
            launch_dir   <= 1'b0;
            slot_owner   <= '0;
            p_hits       <= 4'd0;
            n_hits       <= 4'd0;
        end else begin
            fs_meta      <= frame_clk;
            fs_sync      <= fs_meta;
            fs_prev      <= fs_sync;
            tick         <= fs_sync & ~fs_prev;
            run          <= 1'b1;
            en_prev      <= enable;
            p_shoot_prev <= p_shoot;
            n_shoot_prev <= n_shoot;
            slot_launch  <= do_grant ? grant_vec : '0;

            if (do_grant) begin
                launch_x   <= spawn_x;
                launch_y   <= spawn_y;
                launch_dir <= grant_owner;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (grant_vec[i]) slot_owner[i] <= grant_owner;
                end
                if (p_pend & n_pend) rr <= ~rr;
            end

            if (!enable) begin
                p_pend <= 1'b0;
                n_pend <= 1'b0;
                p_cd   <= 6'd0;
                n_cd   <= 6'd0;
            end else begin
                if (do_grant && !grant_owner)       p_pend <= 1'b0;
                else if (p_shoot && !p_shoot_prev && p_ready) p_pend <= 1'b1;
                if (do_grant && grant_owner)        n_pend <= 1'b0;
                else if (n_shoot && !n_shoot_prev && n_ready) n_pend <= 1'b1;

                if (do_grant && !grant_owner)       p_cd <= CD_LOAD;
                else if (tick && p_cd != 6'd0)      p_cd <= p_cd - 6'd1;
                if (do_grant && grant_owner)        n_cd <= CD_LOAD;
                else if (tick && n_cd != 6'd0)      n_cd <= n_cd - 6'd1;
            end

            // Counts survive a battle end and clear on the next enable rise.
            if (enable && !en_prev) begin
                p_hits <= 4'd0;
                n_hits <= 4'd0;
            end else if (enable) begin
                p_hits <= (p_hits_sum > 8'd15) ? 4'd15 : p_hits_sum[3:0];
                n_hits <= (n_hits_sum > 8'd15) ? 4'd15 : n_hits_sum[3:0];
            end
        end
    end
endmodule

// File: tb/tb_projectile_scheduler.sv
// Bench for projectile_scheduler: cycle-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_projectile_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       enable = 1'b0;
    logic       p_shoot = 1'b0, n_shoot = 1'b0;
    logic [9:0] p_x = '0, p_y = '0, n_x = '0, n_y = '0;
    logic [3:0] slot_hit = '0, slot_offscreen = '0;
    logic [3:0] slot_launch, slot_active, slot_owner;
    logic [9:0] launch_x, launch_y;
    logic       launch_dir, p_ready, n_ready;
    logic [3:0] p_hits, n_hits;

    int checks = 0;
    int errors = 0;

    projectile_scheduler dut (
        .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk), .enable(enable),
        .p_shoot(p_shoot), .n_shoot(n_shoot), .p_x(p_x), .p_y(p_y), .n_x(n_x), .n_y(n_y),
        .slot_hit(slot_hit), .slot_offscreen(slot_offscreen),
        .slot_launch(slot_launch), .launch_x(launch_x), .launch_y(launch_y),
        .launch_dir(launch_dir), .slot_active(slot_active), .slot_owner(slot_owner),
        .p_ready(p_ready), .n_ready(n_ready), .p_hits(p_hits), .n_hits(n_hits)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: 0 = free, 1 = launching, 2 = active; owner 0 = player.
    int m_state [4];
    bit m_owner [4];
    int m_cd [2];
    bit m_pend [2];
    bit m_prev_sh [2];
    int m_hits [2];
    bit m_pipe [3];
    bit m_rr, m_en_prev, m_run, m_fc_last, m_dir;
    int m_launch, m_lx, m_ly;

    initial begin
        int cnt [2];
        int add [2];
        bit rdy [2];
        bit edg [2];
        bit sh [2];
        bit dec;
        int who, slot;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) begin m_state[i] = 0; m_owner[i] = 0; end
                for (int o = 0; o < 2; o++) begin
                    m_cd[o] = 0; m_pend[o] = 0; m_prev_sh[o] = 0; m_hits[o] = 0;
                end
                for (int k = 0; k < 3; k++) m_pipe[k] = 0;
                m_rr = 0; m_en_prev = 0; m_run = 0; m_fc_last = 0;
                m_launch = 0; m_lx = 0; m_ly = 0; m_dir = 0;
            end else begin
                sh[0] = p_shoot;
                sh[1] = n_shoot;
                dec = m_pipe[2];
                m_pipe[2] = m_pipe[1];
                m_pipe[1] = m_pipe[0];
                m_pipe[0] = frame_clk && !m_fc_last;
                m_fc_last = frame_clk;
                for (int o = 0; o < 2; o++) begin cnt[o] = 0; add[o] = 0; end
                for (int i = 0; i < 4; i++) begin
                    if (m_state[i] != 0) cnt[m_owner[i]]++;
                    if (m_state[i] == 2 && slot_hit[i]) add[m_owner[i]]++;
                end
                for (int o = 0; o < 2; o++) begin
                    rdy[o] = m_run && enable && m_cd[o] == 0 && cnt[o] < 2 && !m_pend[o];
                    edg[o] = sh[o] && !m_prev_sh[o];
                end
                who = -1;
                if (enable) begin
                    if (m_pend[0] && m_pend[1]) who = int'(m_rr);
                    else if (m_pend[0])         who = 0;
                    else if (m_pend[1])         who = 1;
                end
                slot = -1;
                if (who >= 0) begin
                    for (int i = 3; i >= 0; i--) if (m_state[i] == 0) slot = i;
                end
                if (!enable) begin
                    for (int i = 0; i < 4; i++) m_state[i] = 0;
                    for (int o = 0; o < 2; o++) begin m_pend[o] = 0; m_cd[o] = 0; end
                    m_launch = 0;
                end else begin
                    for (int o = 0; o < 2; o++) begin
                        if (!m_en_prev) m_hits[o] = 0;
                        else m_hits[o] = (m_hits[o] + add[o] > 15) ? 15 : m_hits[o] + add[o];
                    end
                    for (int i = 0; i < 4; i++) begin
                        if (m_state[i] == 1) m_state[i] = 2;
                        else if (m_state[i] == 2 && (slot_hit[i] || slot_offscreen[i])) m_state[i] = 0;
                    end
                    m_launch = 0;
                    if (slot >= 0) begin
                        m_state[slot] = 1;
                        m_owner[slot] = (who == 1);
                        m_launch = 1 << slot;
                        m_dir = (who == 1);
                        if (who == 0) begin
                            m_lx = (int'(p_x) + 16 > 639) ? 639 : int'(p_x) + 16;
                            m_ly = int'(p_y);
                        end else begin
                            m_lx = (int'(n_x) < 16) ? 0 : int'(n_x) - 16;
                            m_ly = int'(n_y);
                        end
                        if (m_pend[0] && m_pend[1]) m_rr = !m_rr;
                    end
                    for (int o = 0; o < 2; o++) begin
                        if (who == o && slot >= 0) begin
                            m_pend[o] = 0;
                            m_cd[o] = 15;
                        end else begin
                            if (edg[o] && rdy[o]) m_pend[o] = 1;
                            if (dec && m_cd[o] > 0) m_cd[o]--;
                        end
                    end
                end
                m_en_prev = enable;
                m_prev_sh[0] = sh[0];
                m_prev_sh[1] = sh[1];
                m_run = 1;
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        int e_active, e_owner, e_cnt [2];
        bit e_rdy [2];
        forever begin
            @(negedge clk);
            e_active = 0;
            e_owner = 0;
            e_cnt[0] = 0;
            e_cnt[1] = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_state[i] != 0) begin
                    e_active |= (1 << i);
                    if (m_owner[i]) e_owner |= (1 << i);
                    e_cnt[m_owner[i]]++;
                end
            end
            for (int o = 0; o < 2; o++)
                e_rdy[o] = rst_n && m_run && enable && m_cd[o] == 0 && e_cnt[o] < 2 && !m_pend[o];
            if (!rst_n) begin
                check("rst slot_launch", int'(slot_launch), 0);
                check("rst slot_active", int'(slot_active), 0);
                check("rst slot_owner", int'(slot_owner), 0);
                check("rst hits", int'(p_hits) + int'(n_hits), 0);
                check("rst launch_xy", int'(launch_x) + int'(launch_y) + int'(launch_dir), 0);
                check("rst ready", int'(p_ready) + int'(n_ready), 0);
            end else begin
                check("slot_launch", int'(slot_launch), m_launch);
                check("slot_active", int'(slot_active), e_active);
                check("slot_owner", int'(slot_owner) & e_active, e_owner);
                check("p_ready", int'(p_ready), int'(e_rdy[0]));
                check("n_ready", int'(n_ready), int'(e_rdy[1]));
                check("p_hits", int'(p_hits), m_hits[0]);
                check("n_hits", int'(n_hits), m_hits[1]);
                if (m_launch != 0) begin
                    check("launch_x", int'(launch_x), m_lx);
                    check("launch_y", int'(launch_y), m_ly);
                    check("launch_dir", int'(launch_dir), int'(m_dir));
                end
                if (slot_launch != 0)
                    $display("launch slots=%b x=%0d y=%0d dir=%0d", slot_launch, launch_x, launch_y, launch_dir);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            step(2);
            frame_clk = 1'b0;
            step(2);
        end
    endtask

    initial begin
        // Reset with random inputs.
        rst_n = 1'b0;
        repeat (4) begin
            enable = 1'($urandom_range(0, 1));
            p_shoot = 1'($urandom_range(0, 1));
            n_shoot = 1'($urandom_range(0, 1));
            frame_clk = 1'($urandom_range(0, 1));
            p_x = 10'($urandom_range(0, 1023));
            n_x = 10'($urandom_range(0, 1023));
            slot_hit = 4'($urandom_range(0, 15));
            slot_offscreen = 4'($urandom_range(0, 15));
            step();
            check("reset slot_launch", int'(slot_launch), 0);
            check("reset p_ready", int'(p_ready), 0);
        end
        enable = 1'b1; p_shoot = 0; n_shoot = 0; frame_clk = 0;
        slot_hit = '0; slot_offscreen = '0;
        step();
        rst_n = 1'b1;
        check("release p_ready", int'(p_ready), 0);
        step();
        check("ready after release p", int'(p_ready), 1);
        check("ready after release n", int'(n_ready), 1);
        $display("reset done");

        // Single player shot and its cooldown.
        p_x = 10'd100; p_y = 10'd355;
        p_shoot = 1'b1;
        step();
        check("pending blocks p_ready", int'(p_ready), 0);
        step();
        check("T2 slot_launch", int'(slot_launch), 1);
        check("T2 launch_x", int'(launch_x), 116);
        check("T2 launch_y", int'(launch_y), 355);
        check("T2 launch_dir", int'(launch_dir), 0);
        p_shoot = 1'b0;
        step();
        check("T2 slot_active", int'(slot_active), 1);
        frames(14);
        check("cooldown 14 frames", int'(p_ready), 0);
        frames(1);
        check("cooldown 15 frames", int'(p_ready), 1);
        slot_offscreen = 4'b0001;
        step();
        slot_offscreen = '0;
        check("offscreen frees slot0", int'(slot_active), 0);

        // Simultaneous requests, clamps at both ends.
        p_x = 10'd630; n_x = 10'd10; n_y = 10'd200;
        p_shoot = 1'b1; n_shoot = 1'b1;
        step(2);
        check("T3 first launch", int'(slot_launch), 1);
        check("T3 player clamp", int'(launch_x), 639);
        step();
        check("T3 second launch", int'(slot_launch), 2);
        check("T3 npc clamp", int'(launch_x), 0);
        check("T3 npc y", int'(launch_y), 200);
        check("T3 npc dir", int'(launch_dir), 1);
        p_shoot = 1'b0; n_shoot = 1'b0;
        frames(15);
        p_x = 10'd623; n_x = 10'd16;
        p_shoot = 1'b1; n_shoot = 1'b1;
        step(2);
        check("T3 rr npc first", int'(slot_launch), 4);
        check("T3 rr npc dir", int'(launch_dir), 1);
        check("T3 npc exact 0", int'(launch_x), 0);
        step();
        check("T3 rr player second", int'(slot_launch), 8);
        check("T3 player exact max", int'(launch_x), 639);
        p_shoot = 1'b0; n_shoot = 1'b0;

        // Per-owner limit.
        frames(15);
        check("limit p_ready", int'(p_ready), 0);
        check("limit n_ready", int'(n_ready), 0);
        p_shoot = 1'b1;
        step(2);
        check("limit no launch", int'(slot_launch), 0);
        p_shoot = 1'b0;
        slot_offscreen = 4'b1000;
        step();
        slot_offscreen = '0;
        check("limit freed", int'(slot_active), 7);
        check("limit p_ready back", int'(p_ready), 1);

        // Scoring and saturation.
        slot_hit = 4'b0001; slot_offscreen = 4'b0001;
        step();
        slot_hit = '0; slot_offscreen = '0;
        check("hit+off p_hits", int'(p_hits), 1);
        check("hit+off freed", int'(slot_active), 6);
        slot_hit = 4'b0010;
        step();
        slot_hit = '0;
        check("npc hit n_hits", int'(n_hits), 1);
        for (int it = 0; it < 8; it++) begin
            p_shoot = 1'b1; step(); p_shoot = 1'b0; step();
            frames(15);
            p_shoot = 1'b1; step(); p_shoot = 1'b0; step(2);
            slot_hit = slot_active & ~slot_owner;
            step();
            slot_hit = '0;
            if (it == 0) check("double hit popcount", int'(p_hits), 3);
            frames(15);
        end
        check("p_hits saturate", int'(p_hits), 15);
        check("n_hits unchanged", int'(n_hits), 1);

        // Enable drop with three active slots.
        p_shoot = 1'b1; n_shoot = 1'b1;
        step(3);
        n_shoot = 1'b0;
        step();
        check("three active", int'(slot_active), 7);
        enable = 1'b0;
        step();
        check("disable frees slots", int'(slot_active), 0);
        check("disable no launch", int'(slot_launch), 0);
        check("disable p_ready", int'(p_ready), 0);
        check("disable n_ready", int'(n_ready), 0);
        check("disable p_hits hold", int'(p_hits), 15);
        check("disable n_hits hold", int'(n_hits), 1);
        step();
        enable = 1'b1;
        step();
        check("enable clears p_hits", int'(p_hits), 0);
        check("enable clears n_hits", int'(n_hits), 0);
        check("cooldown cleared", int'(p_ready), 1);
        step(2);
        check("held shoot no fire", int'(slot_launch) | int'(slot_active), 0);
        p_shoot = 1'b0;
        step();
        p_shoot = 1'b1;
        step(2);
        check("new edge fires", int'(slot_launch), 1);
        p_shoot = 1'b0;
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
